// File: rtl/car_pkg.sv
// Shared encodings for the car drive path.
// Owner indices, drive bit positions and arbiter states.
package car_pkg;

  localparam int OWN_MAN  = 0;
  localparam int OWN_SEMI = 1;
  localparam int OWN_AUTO = 2;

  localparam int MV_FWD   = 3;
  localparam int MV_BACK  = 2;
  localparam int MV_LEFT  = 1;
  localparam int MV_RIGHT = 0;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_DRAIN
  } arb_state_t;

  // Clear both bits of any opposing pair.
  function automatic logic [3:0] sanitise(input logic [3:0] c);
    logic [3:0] r;
    r = c;
    if (c[MV_FWD] && c[MV_BACK]) begin
      r[MV_FWD]  = 1'b0;
      r[MV_BACK] = 1'b0;
    end
    if (c[MV_LEFT] && c[MV_RIGHT]) begin
      r[MV_LEFT]  = 1'b0;
      r[MV_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/drive_cmd_filter.sv
// Selects one requester's command by one-hot select
// and removes conflicting direction pairs.
module drive_cmd_filter
  import car_pkg::*;
(
  input  logic [3:0] cmd_man,
  input  logic [3:0] cmd_semi,
  input  logic [3:0] cmd_auto,
  input  logic [2:0] sel,
  output logic [3:0] filt
);

  logic [3:0] raw;

  // One-hot select; no selection yields an all-zero command.
  always_comb begin
    raw = 4'b0000;
    unique case (1'b1)
      sel[OWN_MAN]:  raw = cmd_man;
      sel[OWN_SEMI]: raw = cmd_semi;
      sel[OWN_AUTO]: raw = cmd_auto;
      default:       raw = 4'b0000;
    endcase
  end

  assign filt = sanitise(raw);

endmodule

// File: rtl/drive_arbiter.sv
// Fixed-priority owner of the drive output with dead-time on handover/reversal.
// Optional idle-owner timeout under DRIVE_ARB_WATCHDOG_EN.
module drive_arbiter
  import car_pkg::*;
#(
  parameter int DEAD_TIME   = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] req,
  input  logic [3:0] cmd_man,
  input  logic [3:0] cmd_semi,
  input  logic [3:0] cmd_auto,
  output logic [2:0] grant,
  output logic [3:0] move_signal,
  output logic       busy
);

  localparam int CW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  if (DEAD_TIME < 1) begin : g_bad_dead
    $error("DEAD_TIME must be >= 1");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be >= 1");
  end

  arb_state_t state, next_state;
  logic [2:0] next_grant;
  logic [3:0] next_move;
  logic [CW-1:0] cnt, next_cnt;

  logic [2:0] win;
  logic [2:0] sel;
  logic [3:0] filt;
  logic drop, preempt, reversal, wd_fire, stay;

  assign win[OWN_MAN]  = req[OWN_MAN];
  assign win[OWN_SEMI] = req[OWN_SEMI] & ~req[OWN_MAN];
  assign win[OWN_AUTO] = req[OWN_AUTO] & ~req[OWN_SEMI] & ~req[OWN_MAN];

  assign sel = (state == ARB_GRANT) ? grant : win;

  drive_cmd_filter u_filt (
    .cmd_man  (cmd_man),
    .cmd_semi (cmd_semi),
    .cmd_auto (cmd_auto),
    .sel      (sel),
    .filt     (filt)
  );

  assign drop    = ~|(req & grant);
  assign preempt = |(req & (grant - 3'd1));
  assign reversal =
    (filt[MV_BACK] & move_signal[MV_FWD]) |
    (filt[MV_FWD] & move_signal[MV_BACK]);

`ifdef DRIVE_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd_cnt, next_wd;

  assign wd_fire = (filt == 4'b0000) &&
                   (wd_cnt == WW'(WDOG_CYCLES - 1));

  // Run length of idle filtered commands while staying in GRANT.
  always_comb begin
    next_wd = '0;
    if (stay && filt == 4'b0000)
      next_wd = wd_cnt + WW'(1);
  end

  // Idle-run counter register, cleared on reset and disable.
  always_ff @(posedge clk) begin
    if (rst || !enable) wd_cnt <= '0;
    else                wd_cnt <= next_wd;
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign stay = (state == ARB_GRANT) &&
                !(drop || preempt || reversal || wd_fire);

  // Next-state and registered-output decode.
  always_comb begin
    next_state = state;
    next_grant = grant;
    next_move  = move_signal;
    next_cnt   = cnt;
    unique case (state)
      ARB_IDLE: begin
        next_grant = 3'b000;
        next_move  = 4'b0000;
        if (|req) begin
          next_state = ARB_GRANT;
          next_grant = win;
          next_move  = filt;
        end
      end
      ARB_GRANT: begin
        if (stay) begin
          next_move = filt;
        end else begin
          next_state = ARB_DRAIN;
          next_grant = 3'b000;
          next_move  = 4'b0000;
          next_cnt   = CW'(DEAD_TIME - 1);
        end
      end
      ARB_DRAIN: begin
        next_grant = 3'b000;
        next_move  = 4'b0000;
        if (cnt == '0) begin
          if (|req) begin
            next_state = ARB_GRANT;
            next_grant = win;
            next_move  = filt;
          end else begin
            next_state = ARB_IDLE;
          end
        end else begin
          next_cnt = cnt - CW'(1);
        end
      end
      default: begin
        next_state = ARB_IDLE;
        next_grant = 3'b000;
        next_move  = 4'b0000;
        next_cnt   = '0;
      end
    endcase
  end

  // State and outputs; disable acts exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state       <= ARB_IDLE;
      grant       <= 3'b000;
      move_signal <= 4'b0000;
      cnt         <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      grant       <= next_grant;
      move_signal <= next_move;
      cnt         <= next_cnt;
      busy        <= (next_state != ARB_IDLE);
    end
  end

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with DEAD_TIME=4.
// Watchdog scenario adapts to DRIVE_ARB_WATCHDOG_EN.
module tb_drive_arbiter;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] req;
  logic [3:0] cmd_man;
  logic [3:0] cmd_semi;
  logic [3:0] cmd_auto;
  logic [2:0] grant;
  logic [3:0] move_signal;
  logic       busy;

  int checks = 0;
  int errors = 0;

  drive_arbiter #(
    .DEAD_TIME   (DT),
    .WDOG_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .cmd_man     (cmd_man),
    .cmd_semi    (cmd_semi),
    .cmd_auto    (cmd_auto),
    .grant       (grant),
    .move_signal (move_signal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    cmd_man = 4'b0000;
    cmd_semi = 4'b0000;
    cmd_auto = 4'b0000;
    do_reset();
    checks++;
    if ({grant, move_signal, busy} !== 8'b000_0000_0) begin
      errors++;
      $display("FAIL reset: got g=%b m=%b b=%b want 000 0000 0",
               grant, move_signal, busy);
    end
  endtask

  task automatic test_basic_grant();
    req = 3'b100;
    cmd_auto = 4'b1000;
    step(1);
    checks++;
    if ({grant, move_signal, busy} !== 8'b100_1000_1) begin
      errors++;
      $display("FAIL basic_grant: got g=%b m=%b b=%b want 100 1000 1",
               grant, move_signal, busy);
    end
  endtask

  task automatic test_preempt();
    req = 3'b101;
    cmd_man = 4'b0010;
    for (int i = 0; i < DT; i++) begin
      step(1);
      checks++;
      if ({grant, move_signal, busy} !== 8'b000_0000_1) begin
        errors++;
        $display("FAIL preempt_dead[%0d]: got g=%b m=%b b=%b want 000 0000 1",
                 i, grant, move_signal, busy);
      end
    end
    step(1);
    checks++;
    if ({grant, move_signal} !== 7'b001_0010) begin
      errors++;
      $display("FAIL preempt_regrant: got g=%b m=%b want 001 0010",
               grant, move_signal);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    req = 3'b001;
    cmd_man = 4'b1000;
    step(1);
    checks++;
    if ({grant, move_signal} !== 7'b001_1000) begin
      errors++;
      $display("FAIL rev_grant: got g=%b m=%b want 001 1000",
               grant, move_signal);
    end
    cmd_man = 4'b1010;
    step(1);
    checks++;
    if ({grant, move_signal} !== 7'b001_1010) begin
      errors++;
      $display("FAIL turn_no_dead: got g=%b m=%b want 001 1010",
               grant, move_signal);
    end
    cmd_man = 4'b0100;
    for (int i = 0; i < DT; i++) begin
      step(1);
      checks++;
      if ({grant, move_signal} !== 7'b000_0000) begin
        errors++;
        $display("FAIL rev_dead[%0d]: got g=%b m=%b want 000 0000",
                 i, grant, move_signal);
      end
    end
    step(1);
    checks++;
    if ({grant, move_signal} !== 7'b001_0100) begin
      errors++;
      $display("FAIL rev_regrant: got g=%b m=%b want 001 0100",
               grant, move_signal);
    end
  endtask

  task automatic test_filter();
    do_reset();
    req = 3'b010;
    cmd_semi = 4'b1111;
    step(1);
    checks++;
    if ({grant, move_signal} !== 7'b010_0000) begin
      errors++;
      $display("FAIL filt_1111: got g=%b m=%b want 010 0000",
               grant, move_signal);
    end
    cmd_semi = 4'b1011;
    step(1);
    checks++;
    if (move_signal !== 4'b1000) begin
      errors++;
      $display("FAIL filt_1011: got m=%b want 1000", move_signal);
    end
    cmd_semi = 4'b1110;
    step(1);
    checks++;
    if ({grant, move_signal} !== 7'b010_0010) begin
      errors++;
      $display("FAIL filt_1110: got g=%b m=%b want 010 0010",
               grant, move_signal);
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 3'b100;
    cmd_auto = 4'b0000;
    step(1);
    req = 3'b000;
    for (int i = 0; i < DT; i++) begin
      step(1);
      checks++;
      if ({grant, busy} !== 4'b000_1) begin
        errors++;
        $display("FAIL rel_drain[%0d]: got g=%b b=%b want 000 1",
                 i, grant, busy);
      end
    end
    step(1);
    checks++;
    if ({grant, move_signal, busy} !== 8'b000_0000_0) begin
      errors++;
      $display("FAIL rel_idle: got g=%b m=%b b=%b want 000 0000 0",
               grant, move_signal, busy);
    end
    do_reset();
    req = 3'b010;
    cmd_semi = 4'b0001;
    step(1);
    req = 3'b000;
    step(1);
    req = 3'b010;
    for (int i = 1; i < DT; i++) begin
      step(1);
      checks++;
      if (grant !== 3'b000) begin
        errors++;
        $display("FAIL mid_drain_req[%0d]: got g=%b want 000", i, grant);
      end
    end
    step(1);
    checks++;
    if ({grant, move_signal} !== 7'b010_0001) begin
      errors++;
      $display("FAIL drain_exit_grant: got g=%b m=%b want 010 0001",
               grant, move_signal);
    end
  endtask

  task automatic test_disable();
    do_reset();
    req = 3'b001;
    cmd_man = 4'b1000;
    step(1);
    req = 3'b000;
    step(2);
    enable = 1'b0;
    step(1);
    checks++;
    if ({grant, move_signal, busy} !== 8'b000_0000_0) begin
      errors++;
      $display("FAIL disable: got g=%b m=%b b=%b want 000 0000 0",
               grant, move_signal, busy);
    end
    enable = 1'b1;
    req = 3'b001;
    step(1);
    checks++;
    if ({grant, move_signal} !== 7'b001_1000) begin
      errors++;
      $display("FAIL no_dead_after_disable: got g=%b m=%b want 001 1000",
               grant, move_signal);
    end
  endtask

  task automatic test_watchdog();
    int k;
    do_reset();
    req = 3'b001;
    cmd_man = 4'b0000;
    step(1);
`ifdef DRIVE_ARB_WATCHDOG_EN
    k = 0;
    while (grant !== 3'b000 && k < 20) begin
      step(1);
      k++;
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL wdog_fire: got drop after %0d cycles want 8", k);
    end
    step(DT);
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL wdog_regrant: got g=%b want 001", grant);
    end
`else
    k = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (grant !== 3'b001) k++;
    end
    checks++;
    if (k != 0) begin
      errors++;
      $display("FAIL hold_no_wdog: got %0d cycles without grant want 0", k);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    req = 3'b000;
    cmd_man = 4'b0000;
    cmd_semi = 4'b0000;
    cmd_auto = 4'b0000;
    step(1);
    test_reset();
    test_basic_grant();
    test_preempt();
    test_reversal();
    test_filter();
    test_release();
    test_disable();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
- Shares the car's single drive output (move_signal = {forward, backward, left, right}) between three requesters: manual, semi-auto and auto controllers.
- Grants ownership by fixed priority.
- Enforces a dead-time of all-zero drive whenever ownership changes or the owner reverses direction.
- Sanitises conflicting commands.
- Sits between the mode controllers and SimulatedDevice, replacing the per-signal mux selection.

Parameters:
- DEAD_TIME, 4, number of cycles move_signal is forced to 0 on handover/reversal; legal range >= 1.
- WDOG_CYCLES, 1024, idle-owner timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock (divided car clock)
- rst  in  1  synchronous active-high reset
- enable  in  1  arbiter enable; low means power off/mode off
- req  in  3  request per requester: [0] manual, [1] semi, [2] auto
- cmd_man  in  4  manual command {fwd, back, left, right}
- cmd_semi  in  4  semi-auto command, same bit order
- cmd_auto  in  4  auto command, same bit order
- grant  out  3  one-hot current owner, bit index as req; 000 = none
- move_signal  out  4  registered drive output {fwd, back, left, right}
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset and disable:
  - rst=1 at an edge: state IDLE, grant=000, move_signal=0000, dead counter=0.
  - enable=0 behaves identically to rst, and takes priority over all transitions.
  - rst mid-DRAIN or mid-GRANT aborts immediately; no dead-time is owed after reset.
- Filter, applied to the owner's cmd:
  - fwd&back both 1: both forced to 0.
  - left&right both 1: both forced to 0.
  - Other bits pass unchanged.
- Priority: manual > semi > auto; winner = lowest set index of req.
- All outputs are registered.
- IDLE (grant=000, move_signal=0):
  - If any req=1 at an edge, go to GRANT with grant=winner.
  - At that same edge, move_signal <= filt(cmd_winner).
  - Latency req to grant and to move_signal is 1 edge.
- GRANT, each edge, evaluated in this order:
  - Owner req=0: go to DRAIN.
  - A higher-priority req=1: go to DRAIN (preemption).
  - Reversal: filt(cmd_owner) has back=1 while move_signal fwd=1, or fwd=1 while move_signal back=1. Go to DRAIN.
  - Otherwise stay; move_signal <= filt(cmd_owner), which gives 1-cycle command latency.
- On entry to DRAIN:
  - grant <= 000, move_signal <= 0000, counter <= DEAD_TIME-1.
- DRAIN:
  - Hold outputs at 0; decrement the counter each edge.
  - move_signal stays 0 for exactly DEAD_TIME cycles.
  - At the edge where counter==0, re-arbitrate on the req sampled at that edge.
  - If there is a winner, go to GRANT with grant=winner and move_signal <= filt(cmd_winner).
  - Otherwise go to IDLE.
  - req changes during DRAIN are ignored until that exit edge.
- Simultaneous events:
  - Owner drop together with a higher-priority req: a single DRAIN.
  - Reversal together with preemption: a single DRAIN.
  - Turn-bit changes never trigger DRAIN.
- busy = (state != IDLE), registered alongside state.

Optional Feature:
- Macro DRIVE_ARB_WATCHDOG_EN, defined:
  - In GRANT, a counter counts consecutive cycles where filt(cmd_owner)==0000.
  - The counter clears on any nonzero filtered command or on leaving GRANT.
  - At WDOG_CYCLES consecutive idle cycles, go to DRAIN as if the owner had dropped.
  - Re-arbitration at DRAIN exit then follows the normal rule, so the same owner may win again if its req is still high.
- Macro not defined: no counter is present; ownership is held indefinitely while the owner's req=1.

Decomposition:
- Package car_pkg:
  - Owner indices OWN_MAN=0, OWN_SEMI=1, OWN_AUTO=2.
  - Drive bit positions MV_FWD=3, MV_BACK=2, MV_LEFT=1, MV_RIGHT=0.
  - State encoding ARB_IDLE, ARB_GRANT, ARB_DRAIN.
- One sub-module, drive_cmd_filter, combinational:
  - Inputs: the three cmds and the one-hot select.
  - Output: the filtered 4-bit command, so the filter is tested once.
- Priority pick stays inline in drive_arbiter.

Test Plan (all with DEAD_TIME=4):
- Reset/basic grant: rst 1 then 0, req=100, cmd_auto=1000 → grant=100 and move_signal=1000 one edge after req; busy=1.
- Preemption: auto owning with move_signal=1000, then req=101 → next edge grant=000, move_signal=0000 for exactly 4 cycles, then grant=001 and move_signal=cmd_man.
- Reversal: manual owning with move_signal=1000, then cmd_man=0100 → 4 cycles of 0000 with grant=000, then grant=001 and move_signal=0100; a turn-only change 1000→1010 gives no dead-time.
- Conflict filter: cmd_semi=1111 with semi owning → move_signal=0000; cmd_semi=1011 → 1000.
- Release to idle: owner drops req with others at 0 → 4 cycles of DRAIN, then IDLE with busy=0; req=010 asserted mid-DRAIN → grant=010 at DRAIN exit, not earlier.
- Disable and watchdog: enable=0 mid-DRAIN → next edge IDLE, all outputs 0. With DRIVE_ARB_WATCHDOG_EN and WDOG_CYCLES=8, owner cmd=0000 for 8 cycles → DRAIN entered, then re-grant to the same owner.
